// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_param
//  Brief    : Single-clock FIFO with occupancy, threshold/error flags, std/FWFT read
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
   parameter int DATA_WIDTH    = 4,
   parameter int ADDR_WIDTH    = 3,
   parameter int FWFT          = 0,
   parameter int AFULL_THRESH  = 6,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic                  clk_in,
   input  logic                  reset_in,
   input  logic                  w_request_in,
   input  logic [DATA_WIDTH-1:0] w_data_in,
   input  logic                  r_request_in,
   input  logic                  clear_err_in,
   output logic [DATA_WIDTH-1:0] r_data_out,
   output logic                  r_valid_out,
   output logic                  full_out,
   output logic                  empty_out,
   output logic                  almost_full_out,
   output logic                  almost_empty_out,
   output logic [ADDR_WIDTH:0]   count_out,
   output logic                  overflow_out,
   output logic                  underflow_out
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

   generate
      if (AEMPTY_THRESH < 0 || AEMPTY_THRESH >= AFULL_THRESH || AFULL_THRESH > DEPTH)
      begin : g_bad_thresh
         $error("sync_fifo_param: need 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
      end
      if (DATA_WIDTH < 1 || ADDR_WIDTH < 1) begin : g_bad_width
         $error("sync_fifo_param: DATA_WIDTH and ADDR_WIDTH must be at least 1");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] w_ptr;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;
   logic                  wr_acc;
   logic                  rd_acc;

   // All status decodes come from the registered count, so they move only at edges.
   assign full_out         = (count == DEPTH_CNT);
   assign empty_out        = (count == '0);
   assign almost_full_out  = (count >= AFULL_CNT);
   assign almost_empty_out = (count <= AEMPTY_CNT);
   assign count_out        = count;
   assign overflow_out     = overflow;
   assign underflow_out    = underflow;

   assign wr_acc = w_request_in && !full_out;
   assign rd_acc = r_request_in && !empty_out;

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         w_ptr <= '0;
         r_ptr <= '0;
         count <= '0;
      end else begin
         if (wr_acc) begin
            w_ptr <= w_ptr + PTR_ONE;
         end
         if (rd_acc) begin
            r_ptr <= r_ptr + PTR_ONE;
         end
         if (wr_acc && !rd_acc) begin
            count <= count + CNT_ONE;
         end else if (rd_acc && !wr_acc) begin
            count <= count - CNT_ONE;
         end
      end
   end

   // Storage is deliberately left unreset; reset still blocks a concurrent write.
   always_ff @(posedge clk_in) begin
      if (!reset_in && wr_acc) begin
         mem[w_ptr] <= w_data_in;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (w_request_in && full_out) begin
            overflow <= 1'b1;
         end else if (clear_err_in) begin
            overflow <= 1'b0;
         end
         if (r_request_in && empty_out) begin
            underflow <= 1'b1;
         end else if (clear_err_in) begin
            underflow <= 1'b0;
         end
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is masked while empty so stale storage never reaches the port.
         assign r_data_out  = empty_out ? '0 : mem[r_ptr];
         assign r_valid_out = !empty_out;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] rd_data;
         logic                  rd_valid;

         always_ff @(posedge clk_in) begin
            if (reset_in) begin
               rd_data  <= '0;
               rd_valid <= 1'b0;
            end else begin
               rd_valid <= rd_acc;
               if (rd_acc) begin
                  rd_data <= mem[r_ptr];
               end
            end
         end

         assign r_data_out  = rd_data;
         assign r_valid_out = rd_valid;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo_param
//  Brief    : Scoreboard bench for sync_fifo_param, standard and FWFT instances
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       s_rst = 1'b0, s_wr = 1'b0, s_rd = 1'b0, s_clr = 1'b0;
   logic [3:0] s_wd = '0;
   logic [3:0] s_rdata, s_count;
   logic       s_rvalid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;

   logic       f_rst = 1'b0, f_wr = 1'b0, f_rd = 1'b0, f_clr = 1'b0;
   logic [3:0] f_wd = '0;
   logic [3:0] f_rdata, f_count;
   logic       f_rvalid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;

   sync_fifo_param #(.DATA_WIDTH(4), .ADDR_WIDTH(3), .FWFT(0), .AFULL_THRESH(6), .AEMPTY_THRESH(1)) dut_s (
      .clk_in(clk), .reset_in(s_rst), .w_request_in(s_wr), .w_data_in(s_wd),
      .r_request_in(s_rd), .clear_err_in(s_clr), .r_data_out(s_rdata), .r_valid_out(s_rvalid),
      .full_out(s_full), .empty_out(s_empty), .almost_full_out(s_afull),
      .almost_empty_out(s_aempty), .count_out(s_count), .overflow_out(s_ovf), .underflow_out(s_unf)
   );

   sync_fifo_param #(.DATA_WIDTH(4), .ADDR_WIDTH(3), .FWFT(1), .AFULL_THRESH(6), .AEMPTY_THRESH(1)) dut_f (
      .clk_in(clk), .reset_in(f_rst), .w_request_in(f_wr), .w_data_in(f_wd),
      .r_request_in(f_rd), .clear_err_in(f_clr), .r_data_out(f_rdata), .r_valid_out(f_rvalid),
      .full_out(f_full), .empty_out(f_empty), .almost_full_out(f_afull),
      .almost_empty_out(f_aempty), .count_out(f_count), .overflow_out(f_ovf), .underflow_out(f_unf)
   );

   int checks = 0;
   int errors = 0;

   logic [3:0] sq[$];
   logic [3:0] s_exp_data  = '0;
   logic       s_exp_valid = 1'b0;
   logic       s_exp_ovf   = 1'b0;
   logic       s_exp_unf   = 1'b0;
   logic [3:0] fq[$];

   // One clock on the standard instance; the scoreboard advances with the edge.
   task automatic step_s(input logic rst, input logic wr, input logic [3:0] d,
                         input logic rd, input logic clr);
      logic full_b, empty_b, wa, ra;
      s_rst = rst; s_wr = wr; s_wd = d; s_rd = rd; s_clr = clr;
      full_b  = (sq.size() == 8);
      empty_b = (sq.size() == 0);
      wa = wr && !full_b;
      ra = rd && !empty_b;
      @(posedge clk);
      #1;
      if (rst) begin
         sq.delete();
         s_exp_data = '0; s_exp_valid = 1'b0; s_exp_ovf = 1'b0; s_exp_unf = 1'b0;
      end else begin
         s_exp_valid = ra;
         if (ra) s_exp_data = sq.pop_front();
         if (wa) sq.push_back(d);
         if (wr && full_b) s_exp_ovf = 1'b1; else if (clr) s_exp_ovf = 1'b0;
         if (rd && empty_b) s_exp_unf = 1'b1; else if (clr) s_exp_unf = 1'b0;
      end
      s_rst = 1'b0; s_wr = 1'b0; s_rd = 1'b0; s_clr = 1'b0;
   endtask

   task automatic step_f(input logic rst, input logic wr, input logic [3:0] d, input logic rd);
      logic full_b, empty_b;
      f_rst = rst; f_wr = wr; f_wd = d; f_rd = rd; f_clr = 1'b0;
      full_b  = (fq.size() == 8);
      empty_b = (fq.size() == 0);
      @(posedge clk);
      #1;
      if (rst) fq.delete();
      else begin
         if (rd && !empty_b) void'(fq.pop_front());
         if (wr && !full_b) fq.push_back(d);
      end
      f_rst = 1'b0; f_wr = 1'b0; f_rd = 1'b0;
   endtask

   task automatic test_reset();
      step_s(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      step_s(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      step_f(1'b1, 1'b0, 4'h0, 1'b0);
      checks++;
      if ({s_count, s_empty, s_aempty, s_full, s_afull} !== {4'd0, 4'b1100}) begin
         errors++;
         $display("FAIL reset_std_status: got cnt=%0d e=%b ae=%b f=%b af=%b, expected cnt=0 e=1 ae=1 f=0 af=0",
                  s_count, s_empty, s_aempty, s_full, s_afull);
      end
      checks++;
      if ({s_rdata, s_rvalid, s_ovf, s_unf} !== 7'b0) begin
         errors++;
         $display("FAIL reset_std_out: got data=%h v=%b ovf=%b unf=%b, expected all zero",
                  s_rdata, s_rvalid, s_ovf, s_unf);
      end
      checks++;
      if ({f_count, f_empty, f_rvalid, f_rdata} !== {4'd0, 1'b1, 1'b0, 4'h0}) begin
         errors++;
         $display("FAIL reset_fwft: got cnt=%0d e=%b v=%b data=%h, expected cnt=0 e=1 v=0 data=0",
                  f_count, f_empty, f_rvalid, f_rdata);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         step_s(1'b0, 1'b1, 4'(i), 1'b0, 1'b0);
         checks++;
         if (s_count !== 4'(i + 1)) begin
            errors++;
            $display("FAIL fill_count[%0d]: got %0d, expected %0d", i, s_count, i + 1);
         end
         checks++;
         if (s_afull !== (i + 1 >= 6) || s_full !== (i + 1 == 8)) begin
            errors++;
            $display("FAIL fill_flags[%0d]: got af=%b f=%b, expected af=%b f=%b",
                     i, s_afull, s_full, (i + 1 >= 6), (i + 1 == 8));
         end
      end
      step_s(1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
      checks++;
      if (s_count !== 4'd8 || s_ovf !== 1'b1) begin
         errors++;
         $display("FAIL fill_overflow: got cnt=%0d ovf=%b, expected cnt=8 ovf=1", s_count, s_ovf);
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 8; i++) begin
         step_s(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
         checks++;
         if (s_rvalid !== 1'b1 || s_rdata !== 4'(i)) begin
            errors++;
            $display("FAIL drain_data[%0d]: got v=%b data=%h, expected v=1 data=%h", i, s_rvalid, s_rdata, 4'(i));
         end
      end
      checks++;
      if (s_empty !== 1'b1 || s_count !== 4'd0) begin
         errors++;
         $display("FAIL drain_empty: got e=%b cnt=%0d, expected e=1 cnt=0", s_empty, s_count);
      end
      step_s(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      checks++;
      if (s_unf !== 1'b1 || s_rdata !== 4'h7 || s_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL drain_underflow: got unf=%b data=%h v=%b, expected unf=1 data=7 v=0", s_unf, s_rdata, s_rvalid);
      end
      step_s(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
      checks++;
      if (s_ovf !== 1'b0 || s_unf !== 1'b0) begin
         errors++;
         $display("FAIL drain_clear: got ovf=%b unf=%b, expected both 0", s_ovf, s_unf);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 3; i++) step_s(1'b0, 1'b1, 4'(i), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step_s(1'b0, 1'b1, 4'(i + 4), 1'b1, 1'b0);
         checks++;
         if (s_count !== 4'd3 || s_rvalid !== 1'b1 || s_rdata !== s_exp_data) begin
            errors++;
            $display("FAIL stream[%0d]: got cnt=%0d v=%b data=%h, expected cnt=3 v=1 data=%h",
                     i, s_count, s_rvalid, s_rdata, s_exp_data);
         end
      end
   endtask

   task automatic test_boundary();
      for (int i = 0; i < 5; i++) step_s(1'b0, 1'b1, 4'(i + 8), 1'b0, 1'b0);
      step_s(1'b0, 1'b1, 4'h9, 1'b1, 1'b0);
      checks++;
      if (s_count !== 4'd7 || s_ovf !== 1'b1 || s_rvalid !== 1'b1 || s_rdata !== s_exp_data) begin
         errors++;
         $display("FAIL both_at_full: got cnt=%0d ovf=%b v=%b data=%h, expected cnt=7 ovf=1 v=1 data=%h",
                  s_count, s_ovf, s_rvalid, s_rdata, s_exp_data);
      end
      for (int i = 0; i < 7; i++) begin
         step_s(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
         checks++;
         if (s_rvalid !== 1'b1 || s_rdata !== s_exp_data) begin
            errors++;
            $display("FAIL boundary_drain[%0d]: got v=%b data=%h, expected v=1 data=%h", i, s_rvalid, s_rdata, s_exp_data);
         end
      end
      step_s(1'b0, 1'b1, 4'h6, 1'b1, 1'b0);
      checks++;
      if (s_count !== 4'd1 || s_unf !== 1'b1 || s_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL both_at_empty: got cnt=%0d unf=%b v=%b, expected cnt=1 unf=1 v=0", s_count, s_unf, s_rvalid);
      end
      step_s(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
      checks++;
      if (s_ovf !== 1'b0 || s_unf !== 1'b0) begin
         errors++;
         $display("FAIL clear_err: got ovf=%b unf=%b, expected both 0", s_ovf, s_unf);
      end
      for (int i = 0; i < 7; i++) step_s(1'b0, 1'b1, 4'(i), 1'b0, 1'b0);
      step_s(1'b0, 1'b1, 4'hE, 1'b0, 1'b1);
      checks++;
      if (s_ovf !== 1'b1 || s_count !== 4'd8) begin
         errors++;
         $display("FAIL set_beats_clear: got ovf=%b cnt=%0d, expected ovf=1 cnt=8", s_ovf, s_count);
      end
   endtask

   task automatic test_fwft();
      step_f(1'b0, 1'b1, 4'hA, 1'b0);
      checks++;
      if (f_rvalid !== 1'b1 || f_rdata !== 4'hA || f_empty !== 1'b0) begin
         errors++;
         $display("FAIL fwft_first: got v=%b data=%h e=%b, expected v=1 data=a e=0", f_rvalid, f_rdata, f_empty);
      end
      step_f(1'b0, 1'b1, 4'hB, 1'b0);
      checks++;
      if (f_rdata !== fq[0] || f_count !== 4'd2) begin
         errors++;
         $display("FAIL fwft_hold: got data=%h cnt=%0d, expected data=%h cnt=2", f_rdata, f_count, fq[0]);
      end
      step_f(1'b0, 1'b0, 4'h0, 1'b1);
      checks++;
      if (f_rvalid !== 1'b1 || f_rdata !== 4'hB || f_count !== 4'd1) begin
         errors++;
         $display("FAIL fwft_pop1: got v=%b data=%h cnt=%0d, expected v=1 data=b cnt=1", f_rvalid, f_rdata, f_count);
      end
      step_f(1'b0, 1'b0, 4'h0, 1'b1);
      checks++;
      if (f_empty !== 1'b1 || f_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL fwft_pop2: got e=%b v=%b, expected e=1 v=0", f_empty, f_rvalid);
      end
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < 3; i++) step_s(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      checks++;
      if (s_count !== 4'd5) begin
         errors++;
         $display("FAIL pre_reset_count: got %0d, expected 5", s_count);
      end
      step_s(1'b1, 1'b1, 4'hC, 1'b1, 1'b0);
      checks++;
      if ({s_count, s_empty, s_aempty, s_full, s_afull} !== {4'd0, 4'b1100}
          || {s_rdata, s_rvalid, s_ovf, s_unf} !== 7'b0) begin
         errors++;
         $display("FAIL midstream_reset: got cnt=%0d e=%b ae=%b f=%b af=%b data=%h v=%b ovf=%b unf=%b, expected 0,1,1,0,0,0,0,0,0",
                  s_count, s_empty, s_aempty, s_full, s_afull, s_rdata, s_rvalid, s_ovf, s_unf);
      end
      step_s(1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
      step_s(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      checks++;
      if (s_rdata !== 4'h3 || s_rvalid !== 1'b1 || s_empty !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_data: got data=%h v=%b e=%b, expected data=3 v=1 e=1", s_rdata, s_rvalid, s_empty);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_back_to_back();
      test_boundary();
      test_fwft();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
